// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-BCD converter.
// Latency: handshake at edge T, result registered at edge T+WIDTH+1, o_valid high the following cycle.
// Backpressure: o_ready is high only in IDLE; i_valid while busy is ignored (no queuing).
//
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid / o_ready    input handshake; i_value sampled only on handshake
//   o_digits             registered BCD result, digit 0 in bits [3:0], held between conversions
//   o_valid              one-cycle pulse marking a new o_digits value
//   o_overflow           registered: last accepted value exceeded 10^DIGITS-1
// Optional feature: define BIN2BCD_SATURATE_EN to saturate o_digits to all 9s on overflow.
module bin2bcd_seq #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [WIDTH-1:0]      i_value,
  output logic [DIGITS*4-1:0]   o_digits,
  output logic                  o_valid,
  output logic                  o_overflow
);

  localparam int          BCD_W   = DIGITS * 4;
  localparam int          CNT_W   = $clog2(WIDTH + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sreg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_q;
  logic               hs;

  assign hs = i_valid && o_ready;

  // Dabble step: every nibble >= 5 gets +3 before the shift so it carries
  // correctly into the next decimal digit.
  always_comb begin
    scratch_adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[d*4 +: 4] >= 4'd5)
        scratch_adj[d*4 +: 4] = scratch[d*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        // cnt reaches zero on this edge: all WIDTH bits have been shifted in.
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sreg       <= '0;
      scratch    <= '0;
      cnt        <= '0;
      ovf_q      <= 1'b0;
      o_digits   <= '0;
      o_valid    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (hs) begin
            sreg    <= i_value;
            scratch <= '0;
            cnt     <= CNT_W'(WIDTH);
            ovf_q   <= (64'(i_value) > MAX_VAL);
          end
        end
        SHIFT: begin
          // Carry out of the top nibble drops off the end, leaving the low
          // DIGITS decimal digits (value mod 10^DIGITS).
          {scratch, sreg} <= {scratch_adj, sreg} << 1;
          cnt             <= cnt - CNT_W'(1);
        end
        DONE: begin
`ifdef BIN2BCD_SATURATE_EN
          o_digits <= ovf_q ? {DIGITS{4'h9}} : scratch;
`else
          o_digits <= scratch;
`endif
          o_overflow <= ovf_q;
          o_valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD output digits.
REQ-002 Parameter: WIDTH, default 14, bit width of the unsigned binary input.
REQ-003 Port: i_clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: i_valid  input  1  upstream asserts when i_value holds a value to convert.
REQ-006 Port: o_ready  output  1  block can accept a value this cycle.
REQ-007 Port: i_value  input  WIDTH  unsigned binary value to convert.
REQ-008 Port: o_digits  output  DIGITS*4  BCD result; digit 0 in bits [3:0]; registered, held stable between conversions.
REQ-009 Port: o_valid  output  1  one-cycle pulse marking a new o_digits value.
REQ-010 Port: o_overflow  output  1  registered; set when the last accepted value exceeded 10^DIGITS-1.

Function
REQ-011 FSM states SHALL be IDLE, SHIFT and DONE; reset state IDLE.
REQ-012 o_ready SHALL be 1 exactly when state is IDLE.
REQ-013 Handshake SHALL occur on a rising edge with i_valid=1 and o_ready=1; i_value is sampled only then; i_valid while o_ready=0 is ignored, with no queuing.
REQ-014 On handshake: latch i_value into a WIDTH-bit shift register, clear a DIGITS*4-bit BCD scratch register, load a cycle counter with WIDTH, go to SHIFT.
REQ-015 Each SHIFT cycle (double-dabble): add 3 to every scratch nibble >= 5, then shift {scratch, shift register} left one bit; the shift-register MSB enters scratch bit 0; decrement the counter.
REQ-016 After exactly WIDTH SHIFT cycles go to DONE; in DONE load o_digits from scratch, pulse o_valid for one cycle, update o_overflow, return to IDLE.
REQ-017 Latency: handshake at edge T; o_digits and o_overflow update at edge T+WIDTH+1, with o_valid=1 for the following cycle only.
REQ-018 Throughput: with i_valid held high, one handshake SHALL occur every WIDTH+2 cycles.
REQ-019 Overflow SHALL be computed at handshake as i_value > 10^DIGITS-1 and registered; o_overflow is visible only from the DONE update.
REQ-020 Without saturation, o_digits SHALL be the low DIGITS decimal digits of i_value; scratch carries out of the top nibble are discarded.
REQ-021 o_digits SHALL NOT change except on a DONE update or on reset, so a downstream display never sees intermediate values.

Reset
REQ-022 Asserting i_rst_n=0 SHALL immediately force state IDLE, o_digits=0, o_valid=0, o_overflow=0, scratch=0 and counter=0; o_ready reads 1 while in reset.
REQ-023 Reset during SHIFT or DONE SHALL abort the conversion; no o_valid pulse follows for the aborted value.
REQ-024 After reset release, the first handshake SHALL be possible on the first rising edge.

Configuration
REQ-025 Macro BIN2BCD_SATURATE_EN defined: when the registered overflow flag is 1, DONE SHALL load o_digits with every nibble 4'h9; o_overflow behaviour is unchanged.
REQ-026 Macro BIN2BCD_SATURATE_EN undefined: o_digits SHALL follow REQ-020 (truncated), with o_overflow still reported.

Verification (DIGITS=4, WIDTH=14)
REQ-027 Reset, then i_value=0 handshake -> after 15 edges o_digits=16'h0000, o_valid one cycle, o_overflow=0.
REQ-028 i_value=1234 -> o_digits=16'h1234 exactly 15 edges after handshake; o_ready low for 15 cycles; then i_value=9999 -> 16'h9999, o_overflow=0.
REQ-029 i_value=12345 -> o_overflow=1; o_digits=16'h2345 without the macro, 16'h9999 with BIN2BCD_SATURATE_EN.
REQ-030 i_valid held high, i_value stepping 7, 42, 16383 -> handshakes 16 cycles apart; o_digits 16'h0007, 16'h0042, then 16'h6383 with o_overflow=1 (16'h9999 with the macro); i_value changes while busy are ignored.
REQ-031 i_rst_n=0 for one cycle, 5 cycles after a handshake of 1234 (previous o_digits=16'h0042) -> o_digits=0 immediately, no o_valid pulse, o_ready=1; the next handshake of 56 yields 16'h0056.
